uart_rx_deserializer: RTL
=========================

Name: uart_rx_deserializer

Overview:
Serial-to-parallel UART receiver for the ICEstick sniffer's host link. It samples an asynchronous idle-high RX line, frames start/data/stop bits, and assembles data bits LSB-first into a parallel word. The word is presented with a valid/ack handshake. It is the receive-side counterpart of the shift-register-based serial transmit path, accepting host commands on the same 8N1 link.

Parameters:
bits, 8, data bits per frame (LSB first, no parity, 1 stop bit)
clks_per_bit, 104, clk cycles per bit period (12 MHz / 115200); must be >= 4

Ports:
clk  input  1  master clock
rst  input  1  reset, synchronous, active-low
rx  input  1  asynchronous serial input, idle HIGH
DATA_out  output  bits  last correctly framed word
valid  output  1  DATA_out holds an unacknowledged word
ack  input  1  consumer acknowledge; clears valid
frame_err  output  1  one-cycle pulse: stop bit sampled LOW
overrun  output  1  sticky: a word completed while valid=1 and ack=0
busy  output  1  HIGH whenever state != IDLE

Behaviour:
- Reset (rst=0 at a clk rising edge): state=IDLE; bit and clock counters=0; 2-flop rx synchronizer=1,1. DATA_out=0, valid=0, frame_err=0, overrun=0, busy=0. Reset applies mid-frame; the partial word is discarded.
- rx passes through a 2-flop synchronizer; rx_s is its output (2-cycle latency). All decisions use rx_s.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: rx_s=0 -> START, clock counter=0. Call this cycle T0.
- START: sample rx_s at T0+clks_per_bit/2 (integer division). If 0 -> DATA, counter=0. If 1 -> IDLE (glitch rejected, no flags).
- DATA: sample every clks_per_bit cycles. Data bit i (i=0..bits-1) is sampled at T0+clks_per_bit/2+(i+1)*clks_per_bit. Shift: shreg <= {rx_s, shreg[bits-1:1]}. After the bits-th sample -> STOP.
- STOP: sample at T0+clks_per_bit/2+(bits+1)*clks_per_bit.
  - rx_s=1: DATA_out<=shreg and valid<=1 on the following edge, then -> IDLE.
  - rx_s=0: frame_err=1 for exactly one cycle; DATA_out and valid unchanged; -> BREAK.
- BREAK: wait until rx_s=1, then -> IDLE. This prevents a held-low line (break) from re-triggering.
- Handshake: valid stays 1 until a cycle with ack=1 and valid=1; valid=0 on the next edge. ack while valid=0 is ignored.
- Overrun: a word completes while valid=1 and ack=0 -> DATA_out overwritten with the new word, valid stays 1, overrun<=1. overrun clears on the next accepted ack (valid=1, ack=1) or on reset.
- Simultaneous events:
  - Completion in the same cycle as an accepted ack: new word loaded, valid stays 1, overrun unchanged (not set).
  - frame_err in the same cycle as ack: both take effect independently.
- Word latency: valid rises at T0+clks_per_bit/2+(bits+1)*clks_per_bit+1. This is 2 cycles later relative to the raw rx falling edge.
- Back-to-back frames: a start bit arriving immediately after the stop sample (stop shortened to half a bit) is accepted.
- Counters are sized as clog2(clks_per_bit) and clog2(bits+1) bits; there is no wrap-around within a frame.

Test Plan:
1. Set clks_per_bit=16, bits=8. Send 0xA5 as 8N1 -> DATA_out=0xA5, valid=1 at T0+8+9*16+1, frame_err never pulses, busy=0 afterwards; ack -> valid=0 next cycle.
2. Drive rx low for 4 clks, then high -> never leaves IDLE past START, valid=0, frame_err=0, busy returns to 0 by T0+9.
3. Send 0x3C with stop bit=0, hold rx low 40 clks, then send 0x81 -> exactly one frame_err pulse, valid=0 and DATA_out=0 after the first frame, then DATA_out=0x81 and valid=1.
4. Send 0x11, then 0x5A with no ack -> DATA_out=0x5A, valid=1, overrun=1; ack -> valid=0, overrun=0.
5. Assert rst=0 for 1 clk during data bit 3 of 0xFF, then send 0x42 -> all outputs 0 after reset, then DATA_out=0x42, valid=1, no frame_err.
6. With valid=1 (word 0x01), raise ack exactly on the completion cycle of 0x02 -> DATA_out=0x02, valid=1, overrun=0.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// 8N1-style UART receiver: synchronizes rx, frames start/data/stop bits LSB-first and
// presents each completed word on a valid/ack handshake with frame-error and overrun status.
`timescale 1ns/1ps
module uart_rx_deserializer #(
  parameter int unsigned bits         = 8,
  parameter int unsigned clks_per_bit = 104
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic [bits-1:0] DATA_out,
  output logic            valid,
  input  logic            ack,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(clks_per_bit);
  localparam int unsigned BitW = $clog2(bits + 1);
  localparam logic [CntW-1:0] HalfM1  = CntW'(clks_per_bit / 2 - 1);
  localparam logic [CntW-1:0] FullM1  = CntW'(clks_per_bit - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(bits - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [bits-1:0]   shreg_q, shreg_d;
  logic [bits-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              rx_meta_q, rx_s_q;
  logic              accept;

  assign accept = valid_q & ack;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = ovr_q;

    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullM1) begin
          cnt_d              = '0;
          shreg_d            = shreg_q >> 1;
          shreg_d[bits-1]    = rx_s_q;
          bit_cnt_d          = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == LastBit) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == FullM1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            // A completion racing an accepted ack leaves overrun as it was.
            if (valid_q && !ack) ovr_d = 1'b1;
            else if (accept)     ovr_d = ovr_q;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign DATA_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != StIdle);

endmodule
